display_scan_bcd: RTL and testbench

//  Multiplexed 7-segment scanner for the irrigation panel; consumes the bcd

---
 rtl/display_scan_bcd_if.sv | 23 ++
 rtl/display_scan_bcd.sv | 143 ++++++++++++++
 tb/tb_display_scan_bcd.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_bcd_if.sv
// Panel-side bundle for the multiplexed 7-segment scanner: frame data in,
// shared segment bus and digit enables out.
interface display_scan_bcd_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] digits_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  blank_lz;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [N_DIGITS-1:0]   an_n;
  logic                  frame_start;

  modport master (
    output digits_in, dp_in, blank_lz,
    input  seg_n, dp_n, an_n, frame_start
  );

  modport slave (
    input  digits_in, dp_in, blank_lz,
    output seg_n, dp_n, an_n, frame_start
  );
endinterface

// File: rtl/display_scan_bcd.sv
// Multiplexed 7-segment scanner: latches one coherent BCD frame, lights one digit
// per slot after an all-off guard interval, active-low decode, leading-zero blanking.
module display_scan_bcd #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  display_scan_bcd_if.slave  bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  logic [CW-1:0]         slot_cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] digits_sh;
  logic [N_DIGITS-1:0]   dp_sh;
  logic                  blank_lz_sh;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [N_DIGITS-1:0]   an_q;
  logic                  frame_start_q;

  logic                  frame_load;
  logic [N_DIGITS-1:0]   lz_blank;
  logic                  zero_above;
  logic [N_DIGITS-1:0]   sel;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [N_DIGITS-1:0]   an_d;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign frame_load = (slot_cnt == '0) && (idx == '0);

  // Walk from the most significant digit down; a digit is a leading zero while
  // every digit at or above it is zero. Digit 0 is always shown.
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      zero_above = zero_above & (digits_sh[4*(N_DIGITS-1-j) +: 4] == 4'd0);
      if (N_DIGITS - 1 - j != 0)
        lz_blank[N_DIGITS-1-j] = blank_lz_sh & zero_above;
    end
  end

  always_comb begin
    sel       = '0;
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        sel[k]    = 1'b1;
        cur_digit = digits_sh[4*k +: 4];
        cur_dp    = dp_sh[k];
        cur_blank = lz_blank[k];
      end
    end
  end

  always_comb begin
    seg_d = '1;
    dp_d  = 1'b1;
    an_d  = '1;
    if (slot_cnt >= GUARD_END && !cur_blank) begin
      seg_d = bcd_to_seg(cur_digit);
      dp_d  = ~cur_dp;
      an_d  = ~sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits_sh   <= '0;
      dp_sh       <= '0;
      blank_lz_sh <= 1'b0;
    end else if (frame_load) begin
      digits_sh   <= bus.digits_in;
      dp_sh       <= bus.dp_in;
      blank_lz_sh <= bus.blank_lz;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q         <= '1;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_load;
    end
  end

  assign bus.seg_n       = seg_q;
  assign bus.dp_n        = dp_q;
  assign bus.an_n        = an_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_bcd.sv
// Directed bench for display_scan_bcd with N_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
module tb_display_scan_bcd;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  logic [6:0] exp_seg [4];
  logic [3:0] exp_lit;
  logic [3:0] exp_dpn;

  display_scan_bcd_if #(.N_DIGITS(4)) bus ();

  display_scan_bcd #(
    .N_DIGITS    (4),
    .REFRESH_DIV (8),
    .GUARD_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_exp(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3,
                         input logic [3:0] lit, input logic [3:0] dpn);
    exp_seg[0] = s0;
    exp_seg[1] = s1;
    exp_seg[2] = s2;
    exp_seg[3] = s3;
    exp_lit    = lit;
    exp_dpn    = dpn;
  endtask

  task automatic restart();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Starts just before a frame-load edge; cycle c is the c-th edge of the frame.
  task automatic scan_frame(input int n_cyc, input int chg_cyc,
                            input logic [15:0] chg_val, input string tag);
    int         slot;
    int         d;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fs;
    logic       chk_seg;
    for (int c = 1; c <= n_cyc; c++) begin
      tick();
      slot    = (c - 1) % 8;
      d       = ((c - 1) / 8) % 4;
      e_fs    = (c == 1);
      e_an    = 4'hF;
      e_seg   = 7'h7F;
      e_dp    = 1'b1;
      chk_seg = 1'b1;
      if (slot >= 2) begin
        if (exp_lit[d]) begin
          e_an  = ~(4'b0001 << d);
          e_seg = exp_seg[d];
          e_dp  = exp_dpn[d];
        end else begin
          chk_seg = 1'b0;
        end
      end
      n_total++;
      if (bus.an_n !== e_an)
        $display("FAIL %s an_n cycle %0d: got %b want %b", tag, c, bus.an_n, e_an);
      else n_pass++;
      n_total++;
      if (bus.dp_n !== e_dp)
        $display("FAIL %s dp_n cycle %0d: got %b want %b", tag, c, bus.dp_n, e_dp);
      else n_pass++;
      n_total++;
      if (bus.frame_start !== e_fs)
        $display("FAIL %s frame_start cycle %0d: got %b want %b", tag, c, bus.frame_start, e_fs);
      else n_pass++;
      if (chk_seg) begin
        n_total++;
        if (bus.seg_n !== e_seg)
          $display("FAIL %s seg_n cycle %0d: got %b want %b", tag, c, bus.seg_n, e_seg);
        else n_pass++;
      end
      n_total++;
      if ($countones(~bus.an_n) > 1)
        $display("FAIL %s an_n one-cold cycle %0d: got %b want at most one low", tag, c, bus.an_n);
      else n_pass++;
      if (c == chg_cyc) bus.digits_in = chg_val;
    end
  endtask

  task automatic test_reset();
    bus.dp_in    = 4'b0000;
    bus.blank_lz = 1'b0;
    reset        = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.digits_in = 16'($urandom);
      tick();
      n_total++;
      if ({bus.an_n, bus.seg_n, bus.dp_n, bus.frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0})
        $display("FAIL reset_hold cycle %0d: got an=%b seg=%b dp=%b fs=%b want an=1111 seg=1111111 dp=1 fs=0",
                 i, bus.an_n, bus.seg_n, bus.dp_n, bus.frame_start);
      else n_pass++;
    end
    bus.digits_in = 16'h1234;
    reset = 1'b1;
    tick();
    n_total++;
    if ({bus.frame_start, bus.an_n} !== {1'b1, 4'hF})
      $display("FAIL reset_release clock1: got fs=%b an=%b want fs=1 an=1111", bus.frame_start, bus.an_n);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.frame_start, bus.an_n} !== {1'b0, 4'hF})
      $display("FAIL reset_release clock2: got fs=%b an=%b want fs=0 an=1111", bus.frame_start, bus.an_n);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.an_n, bus.seg_n} !== {4'b1110, 7'b0011001})
      $display("FAIL reset_release clock3: got an=%b seg=%b want an=1110 seg=0011001", bus.an_n, bus.seg_n);
    else n_pass++;
  endtask

  task automatic test_scan();
    bus.digits_in = 16'h1234;
    bus.dp_in     = 4'b0000;
    bus.blank_lz  = 1'b0;
    set_exp(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111, 4'b1111);
    restart();
    scan_frame(32, 0, 16'h0, "scan_1234");
  endtask

  task automatic test_blanking();
    bus.digits_in = 16'h0050;
    bus.blank_lz  = 1'b1;
    set_exp(7'b1000000, 7'b0010010, 7'h7F, 7'h7F, 4'b0011, 4'b1111);
    scan_frame(32, 0, 16'h0, "blank_0050");
    bus.digits_in = 16'h0000;
    bus.dp_in     = 4'b1110;
    set_exp(7'b1000000, 7'h7F, 7'h7F, 7'h7F, 4'b0001, 4'b1111);
    scan_frame(32, 0, 16'h0, "blank_0000");
  endtask

  task automatic test_dash_dp();
    bus.digits_in = 16'h00A0;
    bus.dp_in     = 4'b0010;
    bus.blank_lz  = 1'b0;
    set_exp(7'b1000000, 7'b0111111, 7'b1000000, 7'b1000000, 4'b1111, 4'b1101);
    scan_frame(32, 0, 16'h0, "dash_dp");
  endtask

  task automatic test_coherent();
    bus.digits_in = 16'h1234;
    bus.dp_in     = 4'b0000;
    bus.blank_lz  = 1'b0;
    set_exp(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111, 4'b1111);
    scan_frame(32, 19, 16'h5678, "coherent_old");
    set_exp(7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010, 4'b1111, 4'b1111);
    scan_frame(32, 0, 16'h0, "coherent_new");
  endtask

  task automatic test_reset_mid();
    bus.digits_in = 16'h1234;
    set_exp(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111, 4'b1111);
    scan_frame(12, 0, 16'h0, "mid_pre");
    #2;
    reset = 1'b0;
    #1;
    n_total++;
    if ({bus.an_n, bus.seg_n, bus.dp_n, bus.frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL mid_reset_async: got an=%b seg=%b dp=%b fs=%b want an=1111 seg=1111111 dp=1 fs=0",
               bus.an_n, bus.seg_n, bus.dp_n, bus.frame_start);
    else n_pass++;
    bus.digits_in = 16'h9876;
    tick();
    n_total++;
    if ({bus.an_n, bus.frame_start} !== {4'hF, 1'b0})
      $display("FAIL mid_reset_hold: got an=%b fs=%b want an=1111 fs=0", bus.an_n, bus.frame_start);
    else n_pass++;
    reset = 1'b1;
    set_exp(7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 4'b1111, 4'b1111);
    scan_frame(32, 0, 16'h0, "mid_restart");
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    reset         = 1'b0;
    bus.digits_in = '0;
    bus.dp_in     = '0;
    bus.blank_lz  = 1'b0;
    test_reset();
    test_scan();
    test_blanking();
    test_dash_dp();
    test_coherent();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
